// File: rtl/cpc_bus_buffer_ctrl.sv
// Buffer-board controller between the CPC edge connector and the backplane:
// data buffer enable/direction with turnaround, ROMDIS/RAMDIS merge, stretched slot reset.
module cpc_bus_buffer_ctrl #(
  parameter int NSLOTS      = 3,
  parameter int RST_STRETCH = 16,
  parameter int TURN_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RESET_B,
  input  logic              MREQ_B,
  input  logic              IOREQ_B,
  input  logic              RD_B,
  input  logic              WR_B,
  input  logic              M1_B,
  input  logic              RFSH_B,
  input  logic [NSLOTS-1:0] slot_romdis,
  input  logic [NSLOTS-1:0] slot_ramdis,
  output logic              DBUF_OE_B,
  output logic              DBUF_DIR,
  output logic              ROMDIS,
  output logic              RAMDIS,
  output logic              SLOT_RESET_B,
  output logic              BUS_ERR
);

  localparam int SW = $clog2(RST_STRETCH) + 1;
  localparam int TW = $clog2(TURN_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_TURN} state_t;

  logic          r_rstb_s1, r_rstb_s2;
  logic [SW-1:0] r_stretch;
  logic          r_slot_rst_b;
  state_t        r_state, w_state_nxt;
  logic          r_dir, w_dir_nxt;
  logic          r_tgt, w_tgt_nxt;
  logic [TW-1:0] r_turn, w_turn_nxt;
  logic          r_oe_b;
  logic          r_bus_err;
  logic          w_rst_s;
  logic          w_wr_req, w_rd_req, w_conflict;

  // No reset on the synchroniser so RESET alone does not lengthen the stretch.
  always_ff @(posedge CLK) begin
    r_rstb_s1 <= RESET_B;
    r_rstb_s2 <= r_rstb_s1;
  end

  assign w_rst_s = RESET | ~r_rstb_s2;

  always_ff @(posedge CLK) begin
    if (w_rst_s) begin
      r_stretch    <= SW'(RST_STRETCH);
      r_slot_rst_b <= 1'b0;
    end else if (r_stretch != '0) begin
      r_stretch <= r_stretch - SW'(1);
      if (r_stretch == SW'(1)) r_slot_rst_b <= 1'b1;
    end
  end

  // Overlay claims must reach the CPC within the same bus cycle.
  assign ROMDIS = (|slot_romdis) & r_slot_rst_b;
  assign RAMDIS = (|slot_ramdis) & r_slot_rst_b;

  assign w_conflict = ~RD_B & ~WR_B;
  assign w_wr_req   = ~WR_B & RD_B & (~MREQ_B | ~IOREQ_B) & RFSH_B;
  assign w_rd_req   = ~RD_B & WR_B & RFSH_B &
                      ((~MREQ_B & (ROMDIS | RAMDIS)) | (~IOREQ_B & M1_B));

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_tgt_nxt   = r_tgt;
    w_turn_nxt  = r_turn;
    case (r_state)
      S_IDLE: begin
        if (w_wr_req) begin
          if (r_dir) begin
            w_state_nxt = S_WRITE;
          end else begin
            w_state_nxt = S_TURN;
            w_tgt_nxt   = 1'b1;
            w_turn_nxt  = TW'(TURN_CYCLES - 1);
          end
        end else if (w_rd_req) begin
          if (!r_dir) begin
            w_state_nxt = S_READ;
          end else begin
            w_state_nxt = S_TURN;
            w_tgt_nxt   = 1'b0;
            w_turn_nxt  = TW'(TURN_CYCLES - 1);
          end
        end
      end
      S_WRITE: if (!w_wr_req) w_state_nxt = S_IDLE;
      S_READ:  if (!w_rd_req) w_state_nxt = S_IDLE;
      S_TURN: begin
        if (r_turn == '0) begin
          w_dir_nxt   = r_tgt;
          w_state_nxt = S_IDLE;
        end else begin
          w_turn_nxt = r_turn - TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_rst_s) begin
      w_state_nxt = S_IDLE;
      w_dir_nxt   = r_dir;
      w_turn_nxt  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_dir     <= 1'b1;
      r_tgt     <= 1'b1;
      r_turn    <= '0;
      r_oe_b    <= 1'b1;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir     <= w_dir_nxt;
      r_tgt     <= w_tgt_nxt;
      r_turn    <= w_turn_nxt;
      r_oe_b    <= ~((w_state_nxt == S_WRITE) || (w_state_nxt == S_READ));
      r_bus_err <= r_bus_err | w_conflict;
    end
  end

  assign DBUF_OE_B    = r_oe_b;
  assign DBUF_DIR     = r_dir;
  assign SLOT_RESET_B = r_slot_rst_b;
  assign BUS_ERR      = r_bus_err;

endmodule

// File: tb/tb_cpc_bus_buffer_ctrl.sv
// Bench for cpc_bus_buffer_ctrl: behavioural model compared every cycle plus
// hand-computed directed expectations.
module tb_cpc_bus_buffer_ctrl;
  localparam int NS = 3;
  localparam int RS = 16;
  localparam int TC = 1;

  logic CLK = 1'b0;
  logic RESET, RESET_B, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B;
  logic [NS-1:0] slot_romdis, slot_ramdis;
  logic DBUF_OE_B, DBUF_DIR, ROMDIS, RAMDIS, SLOT_RESET_B, BUS_ERR;

  int n_checks = 0;
  int n_err    = 0;

  cpc_bus_buffer_ctrl #(.NSLOTS(NS), .RST_STRETCH(RS), .TURN_CYCLES(TC)) dut (
    .CLK(CLK), .RESET(RESET), .RESET_B(RESET_B), .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B),
    .RD_B(RD_B), .WR_B(WR_B), .M1_B(M1_B), .RFSH_B(RFSH_B),
    .slot_romdis(slot_romdis), .slot_ramdis(slot_ramdis),
    .DBUF_OE_B(DBUF_OE_B), .DBUF_DIR(DBUF_DIR), .ROMDIS(ROMDIS), .RAMDIS(RAMDIS),
    .SLOT_RESET_B(SLOT_RESET_B), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Model: bus enabled flag, direction, pending turnaround, edges since reset cleared.
  bit       m_valid = 0;
  bit [1:0] m_hist  = 2'b00;
  int       m_since = 0;
  bit       m_dir = 1, m_on = 0, m_turning = 0, m_tgt = 1, m_err = 0;
  int       m_left = 0;

  always @(posedge CLK) begin
    automatic bit rst_s  = RESET || !m_hist[1];
    automatic bit slot   = (m_since >= RS);
    automatic bit claim  = slot && ((|slot_romdis) || (|slot_ramdis));
    automatic bit wr     = !WR_B && RD_B && (!MREQ_B || !IOREQ_B) && RFSH_B;
    automatic bit rd     = !RD_B && WR_B && RFSH_B &&
                           ((!MREQ_B && claim) || (!IOREQ_B && M1_B));
    m_hist <= {m_hist[0], RESET_B};
    if (rst_s) m_since <= 0;
    else if (m_since < RS) m_since <= m_since + 1;
    if (RESET) begin
      m_valid <= 1; m_dir <= 1; m_on <= 0; m_turning <= 0; m_err <= 0;
    end else begin
      if (!RD_B && !WR_B) m_err <= 1;
      if (rst_s) begin
        m_on <= 0; m_turning <= 0;
      end else if (m_turning) begin
        if (m_left == 0) begin
          m_dir <= m_tgt; m_turning <= 0;
        end else m_left <= m_left - 1;
      end else if (m_on) begin
        m_on <= m_dir ? wr : rd;
      end else if (wr || rd) begin
        if ((wr && m_dir) || (!wr && !m_dir)) m_on <= 1;
        else begin
          m_turning <= 1; m_tgt <= wr; m_left <= TC - 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("mdl_oe_b",   DBUF_OE_B,    !m_on);
      chk("mdl_dir",    DBUF_DIR,     m_dir);
      chk("mdl_slot",   SLOT_RESET_B, m_since >= RS);
      chk("mdl_buserr", BUS_ERR,      m_err);
      chk("mdl_romdis", ROMDIS,       (|slot_romdis) && (m_since >= RS));
      chk("mdl_ramdis", RAMDIS,       (|slot_ramdis) && (m_since >= RS));
    end
  end

  task automatic next();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle_bus();
    MREQ_B = 1; IOREQ_B = 1; RD_B = 1; WR_B = 1; M1_B = 1; RFSH_B = 1;
    slot_romdis = '0; slot_ramdis = '0;
  endtask

  initial begin
    idle_bus();
    RESET = 1; RESET_B = 1;
    // 1: reset values and stretch
    repeat (3) next();
    chk("rst_oe_b", DBUF_OE_B, 1'b1);
    chk("rst_dir", DBUF_DIR, 1'b1);
    chk("rst_slot", SLOT_RESET_B, 1'b0);
    chk("rst_buserr", BUS_ERR, 1'b0);
    RESET = 0;
    for (int i = 1; i <= RS; i++) begin
      next();
      if (i == RS - 1) chk("stretch_15", SLOT_RESET_B, 1'b0);
      if (i == RS)     chk("stretch_16", SLOT_RESET_B, 1'b1);
    end

    // 2: matched-direction write
    MREQ_B = 0; WR_B = 0;
    next();
    chk("wr_oe_b", DBUF_OE_B, 1'b0);
    chk("wr_dir", DBUF_DIR, 1'b1);
    next(); next();
    chk("wr_hold_oe_b", DBUF_OE_B, 1'b0);
    idle_bus();
    next();
    chk("wr_release", DBUF_OE_B, 1'b1);

    // 3: claimed read reverses, then write reverses back
    MREQ_B = 0; RD_B = 0; slot_romdis = 3'b010;
    #1 chk("romdis_comb", ROMDIS, 1'b1);
    next();
    chk("turn_oe_b", DBUF_OE_B, 1'b1);
    chk("turn_dir", DBUF_DIR, 1'b1);
    next();
    chk("flip_dir", DBUF_DIR, 1'b0);
    chk("flip_oe_b", DBUF_OE_B, 1'b1);
    next();
    chk("rd_oe_b", DBUF_OE_B, 1'b0);
    RD_B = 1; WR_B = 0;
    next();
    chk("rd_end_oe_b", DBUF_OE_B, 1'b1);
    next(); next();
    chk("back_dir", DBUF_DIR, 1'b1);
    chk("back_oe_b", DBUF_OE_B, 1'b1);
    next();
    chk("wr2_oe_b", DBUF_OE_B, 1'b0);
    idle_bus();
    next();

    // 4: unclaimed read, refresh, interrupt acknowledge
    MREQ_B = 0; RD_B = 0;
    next(); next();
    chk("unclaimed_oe_b", DBUF_OE_B, 1'b1);
    slot_romdis = 3'b001; RFSH_B = 0;
    next(); next();
    chk("rfsh_oe_b", DBUF_OE_B, 1'b1);
    idle_bus();
    M1_B = 0; IOREQ_B = 0; RD_B = 0;
    next(); next();
    chk("iack_oe_b", DBUF_OE_B, 1'b1);
    chk("iack_dir", DBUF_DIR, 1'b1);
    idle_bus();
    next();

    // 5: read/write conflict is sticky
    MREQ_B = 0; RD_B = 0; WR_B = 0;
    next();
    chk("conflict_err", BUS_ERR, 1'b1);
    chk("conflict_oe_b", DBUF_OE_B, 1'b1);
    idle_bus();
    next(); next(); next();
    chk("err_sticky", BUS_ERR, 1'b1);
    MREQ_B = 0; RD_B = 0; slot_ramdis = 3'b100;
    #1 chk("ramdis_comb", RAMDIS, 1'b1);
    next(); next(); next();
    chk("ram_rd_oe_b", DBUF_OE_B, 1'b0);
    chk("ram_rd_dir", DBUF_DIR, 1'b0);
    idle_bus();
    next();

    // 6: RESET_B during an I/O read
    IOREQ_B = 0; RD_B = 0; slot_romdis = 3'b001;
    next();
    chk("io_rd_oe_b", DBUF_OE_B, 1'b0);
    RESET_B = 0;
    next(); next(); next();
    chk("rstb_oe_b", DBUF_OE_B, 1'b1);
    chk("rstb_slot", SLOT_RESET_B, 1'b0);
    chk("rstb_romdis", ROMDIS, 1'b0);
    chk("rstb_dir_held", DBUF_DIR, 1'b0);
    idle_bus();
    RESET_B = 1;
    for (int i = 1; i <= RS + 2; i++) begin
      next();
      if (i == RS + 1) chk("restretch_17", SLOT_RESET_B, 1'b0);
      if (i == RS + 2) chk("restretch_18", SLOT_RESET_B, 1'b1);
    end
    chk("err_survives_rstb", BUS_ERR, 1'b1);

    RESET = 1;
    next();
    chk("reset_clears_err", BUS_ERR, 1'b0);
    chk("reset_dir", DBUF_DIR, 1'b1);
    RESET = 0;
    next();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
